insert_msa_n_lanes: RTL and testbench

//  Parametrised Main Stream Attribute (MSA) inserter for 1, 2 or 4 DisplayPort lanes, two symbols per lane per clock.

---
 rtl/insert_msa_n_lanes_if.sv | 44 ++++
 rtl/insert_msa_n_lanes.sv | 177 +++++++++++++++++
 tb/tb_insert_msa_n_lanes.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/insert_msa_n_lanes_if.sv
// Symbol-stream bus of the MSA inserter: attribute inputs, lane data in/out and status.
// master drives the stream and attributes; slave is the inserter.
interface insert_msa_n_lanes_if #(
    parameter int LANES    = 4,
    parameter int TIMING_W = 12
);
    logic                   active;
    logic                   force_send;
    logic [23:0]            M_value;
    logic [23:0]            N_value;
    logic [TIMING_W-1:0]    H_visible;
    logic [TIMING_W-1:0]    V_visible;
    logic [TIMING_W-1:0]    H_total;
    logic [TIMING_W-1:0]    V_total;
    logic [TIMING_W-1:0]    H_sync_width;
    logic [TIMING_W-1:0]    V_sync_width;
    logic [TIMING_W-1:0]    H_start;
    logic [TIMING_W-1:0]    V_start;
    logic                   H_sync_active_high;
    logic                   V_sync_active_high;
    logic [7:0]             misc0;
    logic [7:0]             misc1;
    logic [18*LANES-1:0]    in_data;
    logic [18*LANES-1:0]    out_data;
    logic                   msa_busy;
    logic                   msa_done;
    logic [1:0]             state_dbg;

    // Streaming contract: no back-pressure. Every clock carries one valid word per lane
    // (2 symbols each); out_data is in_data one cycle later unless msa_busy marks it replaced.
    modport master (
        output active, force_send, M_value, N_value, H_visible, V_visible, H_total, V_total,
               H_sync_width, V_sync_width, H_start, V_start, H_sync_active_high,
               V_sync_active_high, misc0, misc1, in_data,
        input  out_data, msa_busy, msa_done, state_dbg
    );

    modport slave (
        input  active, force_send, M_value, N_value, H_visible, V_visible, H_total, V_total,
               H_sync_width, V_sync_width, H_start, V_start, H_sync_active_high,
               V_sync_active_high, misc0, misc1, in_data,
        output out_data, msa_busy, msa_done, state_dbg
    );
endinterface

// File: rtl/insert_msa_n_lanes.sv
// MSA inserter for 1/2/4 DisplayPort lanes at two symbols per lane per clock.
// Replaces the blanking symbols after a vblank BS with SS,SS,MSA blocks,SE once per frame.
module insert_msa_n_lanes #(
    parameter int LANES    = 4,
    parameter int TIMING_W = 12
) (
    input logic              clk,
    input logic              rst_n,
    insert_msa_n_lanes_if.slave bus
);
    localparam int SYMS   = 3 + 36 / LANES;
    localparam int CYCLES = (SYMS + 1) / 2;
    localparam int W      = 18 * LANES;

    localparam logic [8:0] SYM_BS = 9'h1BC;
    localparam logic [8:0] SYM_SS = 9'h15C;
    localparam logic [8:0] SYM_SE = 9'h1FD;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("insert_msa_n_lanes: LANES must be 1, 2 or 4");
        end
        if (TIMING_W < 8 || TIMING_W > 16) begin : g_bad_timing_w
            $error("insert_msa_n_lanes: TIMING_W must be 8..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t       state;
    logic [4:0]   cnt;
    logic         armed;
    logic         bs_pend;
    logic [W-1:0] out_q;
    logic         busy_q;
    logic         done_q;

    logic [8:0]   l0_s0;
    logic [8:0]   l0_s1;
    logic         vbid_valid;
    logic [8:0]   vbid;
    logic         trigger;
    logic         armed_next;
    logic [W-1:0] msa_word;

    logic [15:0]  h_total16, v_total16, h_start16, v_start16;
    logic [15:0]  h_vis16, v_vis16, hsw16, vsw16;
    logic [7:0]   blk_byte [4][9];

    assign l0_s0 = bus.in_data[8:0];
    assign l0_s1 = bus.in_data[17:9];

    // VB-ID follows BS directly; a BS in symbol 1 puts it in symbol 0 of the next cycle.
    always_comb begin
        vbid_valid = 1'b0;
        vbid       = l0_s1;
        if (bs_pend) begin
            vbid_valid = 1'b1;
            vbid       = l0_s0;
        end else if (l0_s0 == SYM_BS) begin
            vbid_valid = 1'b1;
            vbid       = l0_s1;
        end
    end

    assign trigger = bus.active && armed && (state == IDLE) && vbid_valid && vbid[0];

    always_comb begin
        armed_next = armed;
        if (trigger)
            armed_next = 1'b0;
        if ((vbid_valid && !vbid[0]) || bus.force_send)
            armed_next = 1'b1;
        if (!bus.active)
            armed_next = 1'b0;
    end

    assign h_total16 = 16'(bus.H_total);
    assign v_total16 = 16'(bus.V_total);
    assign h_start16 = 16'(bus.H_start);
    assign v_start16 = 16'(bus.V_start);
    assign h_vis16   = 16'(bus.H_visible);
    assign v_vis16   = 16'(bus.V_visible);
    assign hsw16     = 16'(bus.H_sync_width);
    assign vsw16     = 16'(bus.V_sync_width);

    always_comb begin
        blk_byte[0] = '{bus.M_value[23:16], bus.M_value[15:8], bus.M_value[7:0],
                        h_total16[15:8], h_total16[7:0], v_total16[15:8], v_total16[7:0],
                        {~bus.H_sync_active_high, hsw16[14:8]}, hsw16[7:0]};
        blk_byte[1] = '{bus.M_value[23:16], bus.M_value[15:8], bus.M_value[7:0],
                        h_start16[15:8], h_start16[7:0], v_start16[15:8], v_start16[7:0],
                        {~bus.V_sync_active_high, vsw16[14:8]}, vsw16[7:0]};
        blk_byte[2] = '{bus.M_value[23:16], bus.M_value[15:8], bus.M_value[7:0],
                        h_vis16[15:8], h_vis16[7:0], v_vis16[15:8], v_vis16[7:0],
                        8'h00, 8'h00};
        blk_byte[3] = '{bus.M_value[23:16], bus.M_value[15:8], bus.M_value[7:0],
                        bus.N_value[23:16], bus.N_value[15:8], bus.N_value[7:0],
                        bus.misc0, bus.misc1, 8'h00};
    end

    // Lane k symbol s: SS for s<2, SE last, else byte (s-2)%9 of block k+((s-2)/9)*LANES.
    always_comb begin
        msa_word = bus.in_data;
        for (int k = 0; k < LANES; k++) begin
            for (int h = 0; h < 2; h++) begin
                int         s;
                int         d;
                logic [8:0] sym;
                s   = 2 * int'(cnt) + h;
                d   = s - 2;
                sym = SYM_SS;
                if (s < SYMS) begin
                    if (s == SYMS - 1)
                        sym = SYM_SE;
                    else if (s >= 2)
                        sym = {1'b0, blk_byte[2'(k + (d / 9) * LANES)][4'(d % 9)]};
                    msa_word[18*k + 9*h +: 9] = sym;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            armed   <= 1'b0;
            bs_pend <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            bs_pend <= (l0_s1 == SYM_BS);
            armed   <= armed_next;
            out_q   <= (state == SEND) ? msa_word : bus.in_data;
            busy_q  <= (state == SEND);
            done_q  <= (state == SEND) && (cnt == 5'(CYCLES - 1));
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (trigger)
                        state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 5'd1) begin
                        state <= SEND;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                SEND: begin
                    if (cnt == 5'(CYCLES - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.out_data  = out_q;
    assign bus.msa_busy  = busy_q;
    assign bus.msa_done  = done_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_insert_msa_n_lanes.sv
// Bench for insert_msa_n_lanes: LANES=4, 2 and 1 instances share one lane-0 stream,
// so they trigger together while their packet lengths differ.
module tb_insert_msa_n_lanes;
  localparam logic [8:0] BS = 9'h1BC;
  localparam logic [8:0] SS = 9'h15C;
  localparam logic [8:0] SE = 9'h1FD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        active = 1'b0;
  logic        force_send = 1'b0;
  logic [23:0] m_value = 24'h012345;
  logic [23:0] n_value = 24'h6789AB;
  logic [11:0] h_visible = 12'd1920;
  logic [11:0] v_visible = 12'd1080;
  logic [11:0] h_total = 12'd2200;
  logic [11:0] v_total = 12'd1125;
  logic [11:0] h_sync_width = 12'd44;
  logic [11:0] v_sync_width = 12'd5;
  logic [11:0] h_start = 12'd192;
  logic [11:0] v_start = 12'd41;
  logic        hsp = 1'b1;
  logic        vsp = 1'b0;
  logic [7:0]  misc0 = 8'h21;
  logic [7:0]  misc1 = 8'h5A;

  insert_msa_n_lanes_if #(.LANES(4), .TIMING_W(12)) b4 ();
  insert_msa_n_lanes_if #(.LANES(2), .TIMING_W(12)) b2 ();
  insert_msa_n_lanes_if #(.LANES(1), .TIMING_W(12)) b1 ();

  insert_msa_n_lanes #(.LANES(4), .TIMING_W(12)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  insert_msa_n_lanes #(.LANES(2), .TIMING_W(12)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  insert_msa_n_lanes #(.LANES(1), .TIMING_W(12)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  assign b4.active = active;       assign b2.active = active;       assign b1.active = active;
  assign b4.force_send = force_send; assign b2.force_send = force_send; assign b1.force_send = force_send;
  assign b4.M_value = m_value;     assign b2.M_value = m_value;     assign b1.M_value = m_value;
  assign b4.N_value = n_value;     assign b2.N_value = n_value;     assign b1.N_value = n_value;
  assign b4.H_visible = h_visible; assign b2.H_visible = h_visible; assign b1.H_visible = h_visible;
  assign b4.V_visible = v_visible; assign b2.V_visible = v_visible; assign b1.V_visible = v_visible;
  assign b4.H_total = h_total;     assign b2.H_total = h_total;     assign b1.H_total = h_total;
  assign b4.V_total = v_total;     assign b2.V_total = v_total;     assign b1.V_total = v_total;
  assign b4.H_sync_width = h_sync_width; assign b2.H_sync_width = h_sync_width; assign b1.H_sync_width = h_sync_width;
  assign b4.V_sync_width = v_sync_width; assign b2.V_sync_width = v_sync_width; assign b1.V_sync_width = v_sync_width;
  assign b4.H_start = h_start;     assign b2.H_start = h_start;     assign b1.H_start = h_start;
  assign b4.V_start = v_start;     assign b2.V_start = v_start;     assign b1.V_start = v_start;
  assign b4.H_sync_active_high = hsp; assign b2.H_sync_active_high = hsp; assign b1.H_sync_active_high = hsp;
  assign b4.V_sync_active_high = vsp; assign b2.V_sync_active_high = vsp; assign b1.V_sync_active_high = vsp;
  assign b4.misc0 = misc0;         assign b2.misc0 = misc0;         assign b1.misc0 = misc0;
  assign b4.misc1 = misc1;         assign b2.misc1 = misc1;         assign b1.misc1 = misc1;

  // Expected word layout: {msa_done, msa_busy, out_data zero-extended to 72 bits}.
  logic [73:0] exp_q4[$];
  logic [73:0] exp_q2[$];
  logic [73:0] exp_q1[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int send_start = -1000;

  logic [8:0] sym_tab [3][4][40];
  int         nsyms [3];

  task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  function automatic int lanes_of(input int cfg);
    return (cfg == 0) ? 4 : (cfg == 1) ? 2 : 1;
  endfunction

  // Per-lane symbol lists written straight from the MSA layout.
  task automatic build_tables();
    logic [7:0]  blk [4][9];
    logic [15:0] ht, vt, hs, vs, hv, vv, hw, vw;
    ht = 16'(h_total); vt = 16'(v_total); hs = 16'(h_start); vs = 16'(v_start);
    hv = 16'(h_visible); vv = 16'(v_visible); hw = 16'(h_sync_width); vw = 16'(v_sync_width);
    blk[0] = '{m_value[23:16], m_value[15:8], m_value[7:0], ht[15:8], ht[7:0], vt[15:8], vt[7:0],
               {~hsp, hw[14:8]}, hw[7:0]};
    blk[1] = '{m_value[23:16], m_value[15:8], m_value[7:0], hs[15:8], hs[7:0], vs[15:8], vs[7:0],
               {~vsp, vw[14:8]}, vw[7:0]};
    blk[2] = '{m_value[23:16], m_value[15:8], m_value[7:0], hv[15:8], hv[7:0], vv[15:8], vv[7:0],
               8'h00, 8'h00};
    blk[3] = '{m_value[23:16], m_value[15:8], m_value[7:0], n_value[23:16], n_value[15:8],
               n_value[7:0], misc0, misc1, 8'h00};
    for (int cfg = 0; cfg < 3; cfg++) begin
      int lanes;
      lanes = lanes_of(cfg);
      for (int l = 0; l < lanes; l++) begin
        int s;
        s = 0;
        sym_tab[cfg][l][s] = SS; s++;
        sym_tab[cfg][l][s] = SS; s++;
        for (int b = l; b < 4; b += lanes)
          for (int i = 0; i < 9; i++) begin
            sym_tab[cfg][l][s] = {1'b0, blk[b][i]};
            s++;
          end
        sym_tab[cfg][l][s] = SE; s++;
        nsyms[cfg] = s;
      end
    end
  endtask

  function automatic logic [73:0] expect_word(input int cfg, input logic [71:0] w);
    logic [73:0] e;
    logic [71:0] mask;
    int lanes, n, ncyc, c;
    lanes = lanes_of(cfg);
    n     = nsyms[cfg];
    ncyc  = (n + 1) / 2;
    mask  = (72'(1) << (18 * lanes)) - 72'(1);
    e     = {2'b00, w & mask};
    c     = cyc - send_start;
    if (c >= 0 && c < ncyc) begin
      for (int l = 0; l < lanes; l++)
        for (int h = 0; h < 2; h++) begin
          int s;
          s = 2 * c + h;
          if (s < n) e[18*l + 9*h +: 9] = sym_tab[cfg][l][s];
        end
      e[72] = 1'b1;
      e[73] = (c == ncyc - 1);
    end
    return e;
  endfunction

  function automatic logic [8:0] rnd_d();
    return {1'b0, 8'($urandom)};
  endfunction

  // One input cycle: lane 0 symbols given, other lanes random; expected pushed once sampled.
  task automatic step(input logic [8:0] s0, input logic [8:0] s1);
    logic [71:0] w;
    for (int l = 1; l < 4; l++) w[18*l +: 18] = 18'($urandom);
    w[17:0] = {s1, s0};
    b4.in_data = w;
    b2.in_data = w[35:0];
    b1.in_data = w[17:0];
    @(posedge clk);
    exp_q4.push_back(expect_word(0, w));
    exp_q2.push_back(expect_word(1, w));
    exp_q1.push_back(expect_word(2, w));
    cyc++;
    #1;
    force_send = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(rnd_d(), rnd_d());
  endtask

  // Arms with an active-line BS, then a blank BS whose VB-ID cycle starts the schedule.
  task automatic arm_and_trigger();
    step(BS, 9'h000);
    idle(2);
    send_start = cyc + 3;
    step(BS, 9'h001);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q4.size() > 0) check("dut4_out", {b4.msa_done, b4.msa_busy, b4.out_data}, exp_q4.pop_front());
      if (exp_q2.size() > 0) check("dut2_out", {b2.msa_done, b2.msa_busy, 36'd0, b2.out_data}, exp_q2.pop_front());
      if (exp_q1.size() > 0) check("dut1_out", {b1.msa_done, b1.msa_busy, 54'd0, b1.out_data}, exp_q1.pop_front());
    end
  end

  initial begin
    b4.in_data = '0; b2.in_data = '0; b1.in_data = '0;
    build_tables();
    repeat (2) @(posedge clk);
    #1;
    check("reset_dut4", {b4.msa_done, b4.msa_busy, b4.out_data}, 74'd0);
    check("reset_dut2", {b2.msa_done, b2.msa_busy, 36'd0, b2.out_data}, 74'd0);
    check("reset_dut1", {b1.msa_done, b1.msa_busy, 54'd0, b1.out_data}, 74'd0);
    check("reset_state", 74'(b4.state_dbg), 74'd0);
    rst_n = 1'b1;
    active = 1'b1;
    idle(3);

    // Active line then blank BS in symbol 0.
    step(BS, 9'h000);
    idle(4);
    send_start = cyc + 3;
    step(BS, 9'h001);
    idle(25);

    // BS in symbol 1 for both the active-line and the blank VB-ID.
    step(rnd_d(), BS);
    step(9'h000, rnd_d());
    idle(3);
    step(rnd_d(), BS);
    send_start = cyc + 3;
    step(9'h001, rnd_d());
    idle(2);
    step(rnd_d(), rnd_d());
    check("l2_ss_ss", 74'(b2.out_data[17:0]), 74'({SS, SS}));
    step(rnd_d(), rnd_d());
    check("l2_m_hi", 74'(b2.out_data[17:0]), 74'({9'h023, 9'h001}));
    step(rnd_d(), rnd_d());
    check("l2_m_lo_ht", 74'(b2.out_data[17:0]), 74'({9'h008, 9'h045}));
    step(rnd_d(), rnd_d());
    check("l2_ht_lo", 74'(b2.out_data[8:0]), 74'(9'h098));
    step(rnd_d(), rnd_d());
    check("l1_hsw_hi", 74'(b1.out_data[17:9]), 74'(9'h000));
    step(rnd_d(), rnd_d());
    check("l1_hsw_lo", 74'(b1.out_data[8:0]), 74'(9'h02C));
    idle(13);
    step(rnd_d(), rnd_d());
    check("l1_se_pos", 74'({b1.msa_done, b1.out_data[8:0]}), 74'({1'b1, SE}));
    idle(5);

    // Blank BS with no active line since the last packet: nothing sent.
    step(BS, 9'h001);
    idle(25);
    step(BS, 9'h001);
    idle(5);

    // force_send arms without an active line; force and blank BS during SEND.
    force_send = 1'b1;
    step(rnd_d(), rnd_d());
    idle(2);
    send_start = cyc + 3;
    step(BS, 9'h001);
    idle(3);
    force_send = 1'b1;
    step(rnd_d(), rnd_d());
    step(BS, 9'h001);
    idle(25);
    send_start = cyc + 3;
    step(BS, 9'h001);
    idle(25);

    // active dropped mid-SEND: packet completes, nothing afterwards.
    arm_and_trigger();
    idle(4);
    active = 1'b0;
    idle(25);
    step(BS, 9'h000);
    idle(2);
    step(BS, 9'h001);
    idle(3);
    for (int i = 0; i < 1000; i++) step(9'($urandom), 9'($urandom));

    // Async reset mid-SEND.
    active = 1'b1;
    arm_and_trigger();
    idle(5);
    #1;
    rst_n = 1'b0;
    exp_q4.delete(); exp_q2.delete(); exp_q1.delete();
    #1;
    check("rst_mid_dut4", {b4.msa_done, b4.msa_busy, b4.out_data}, 74'd0);
    check("rst_mid_dut2", {b2.msa_done, b2.msa_busy, 36'd0, b2.out_data}, 74'd0);
    check("rst_mid_dut1", {b1.msa_done, b1.msa_busy, 54'd0, b1.out_data}, 74'd0);
    @(posedge clk);
    #1;
    check("rst_hold_dut1", {b1.msa_done, b1.msa_busy, 54'd0, b1.out_data}, 74'd0);
    send_start = -1000;
    rst_n = 1'b1;
    idle(3);
    step(BS, 9'h001);
    idle(25);
    arm_and_trigger();
    idle(25);

    @(negedge clk);
    #1;
    check("queues_drained", 74'(exp_q4.size() + exp_q2.size() + exp_q1.size()), 74'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
